seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Run-time controller for the serial sequence detectors. It holds a programmable pattern of up to PAT_W bits, arms on a start pulse, and scans a qualified serial bit stream. Overlapping matches are counted. A run stops on reaching a target match count or on a bit-count timeout, and status is reported to the host-side control logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match target and match counter
TO_W, 16, width of timeout bit counter
LEN_W, $clog2(PAT_W)+1 (localparam), width of cfg_len

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
cfg_load  input  1  capture cfg_* fields; ignored while busy
cfg_pattern  input  PAT_W  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  pattern length; legal range 1..PAT_W
cfg_target  input  CNT_W  matches required for done; legal range 1..2^CNT_W-1
cfg_timeout  input  TO_W  accepted-bit budget; 0 disables the timeout
start  input  1  arm a run (pulse)
abort  input  1  cancel a run (pulse)
x  input  1  serial data bit
x_valid  input  1  x is qualified this cycle
match  output  1  one-cycle pulse per detected pattern
match_cnt  output  CNT_W  matches in the current or last run
busy  output  1  run in progress
done  output  1  target reached (level)
timeout  output  1  budget exhausted before target (level)
cfg_err  output  1  last start was rejected for an illegal config (level)

Behaviour:
- States: IDLE, RUN, DONE, TMO. Reset (rst low) forces IDLE.
- Reset values: all outputs 0; config registers pattern=0, len=0, target=0, timeout=0; history, bit counters and match_cnt = 0.
- cfg_load: captured in IDLE, DONE and TMO. Dropped in RUN, with no side effect.
- start outside RUN:
  - Illegal config (len==0, len>PAT_W or target==0): go to IDLE, cfg_err=1, nothing else changes.
  - Otherwise: clear history, bits_seen, bit counter and match_cnt; drop done, timeout and cfg_err; enter RUN next cycle with busy=1.
- start while in RUN: ignored.
- RUN, per x_valid cycle:
  - Candidate window = {history[PAT_W-2:0], x}.
  - Hit when bits_seen+1 >= len and the low len bits of the window equal the low len bits of the pattern.
  - History shifts with the new bit at LSB; bits_seen saturates at PAT_W; the bit counter increments.
- Cycles in RUN without x_valid: no state change.
- Latency: match pulses and match_cnt increments on the clock edge that samples the hit bit, so they are visible the following cycle. Overlap is allowed: history is never cleared on a hit.
- Run end conditions:
  - Hit making match_cnt == target: go to DONE (done=1, busy=0) on the same edge.
  - timeout!=0 and the bit counter reaches cfg_timeout with no target hit: go to TMO (timeout=1, busy=0).
  - Target hit and timeout on the same bit: DONE wins and timeout stays 0.
- match_cnt cannot overflow, because the run stops at target.
- abort:
  - In RUN: go to IDLE next cycle; busy=0, done=0, timeout=0, match_cnt held.
  - In DONE or TMO: go to IDLE and clear done and timeout.
  - abort and start asserted together: abort wins.
- DONE and TMO hold until start (re-arm) or abort. x_valid is ignored outside RUN.
- Reset mid-run: immediate asynchronous return to reset values, including the config registers.

Decomposition:
- Package seq_ctrl_pkg:
  - state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10, TMO=2'b11
  - default PAT_W, CNT_W, TO_W
  - LEN_W derivation
- One sub-module, seq_window_match: PAT_W history shift register, bits_seen saturation and the length-masked compare, with a combinational hit output.
- The FSM, counters and config registers stay in seq_detect_ctrl.

Test Plan:
- Basic run: pattern=3'b110, len=3, target=2, timeout=0; stream 1,1,0,1,1,0 -> match after bits 3 and 6, match_cnt=2, done=1 and busy=0 after bit 6.
- Overlap: pattern=3'b101, len=3, target=2; stream 1,0,1,0,1 -> matches after bits 3 and 5, done=1.
- Timeout: pattern=110, target=3, timeout=5; stream 1,1,0,0,0 -> match_cnt=1, timeout=1, done=0.
- Done wins on tie: pattern=110, target=1, timeout=3; stream 1,1,0 -> done=1, timeout=0.
- Run control: abort after 2 bits -> IDLE, busy=0. Then cfg_load with len=0 and start -> cfg_err=1, stays IDLE. cfg_load during RUN -> pattern unchanged.
- Reset: rst low mid-run with match_cnt=1 -> all outputs 0 immediately. After release, start without reconfig -> cfg_err=1.

Source files
------------

// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the serial sequence-detector run controller.
package seq_ctrl_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_TO_W  = 16;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Host-side configuration, serial stream and status bundle of the detector controller.
interface seq_detect_ctrl_if
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TO_W  = DEF_TO_W
);
  localparam int LEN_W = len_w(PAT_W);

  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic [TO_W-1:0]  cfg_timeout;
  logic             start;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             cfg_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
    output start, abort, x, x_valid,
    input  match, match_cnt, busy, done, timeout, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
    input  start, abort, x, x_valid,
    output match, match_cnt, busy, done, timeout, cfg_err
  );

endinterface

// File: rtl/seq_window_match.sv
// Bit history, saturating fill count and length-masked pattern compare.
module seq_window_match
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  // Only PAT_W-1 past bits are ever compared, so the oldest bit is not stored.
  logic [PAT_W-2:0] history;
  logic [LEN_W-1:0] bits_seen;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic             enough;

  assign window = {history, x};
  assign enough = ({1'b0, bits_seen} + (LEN_W+1)'(1)) >= {1'b0, len};

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      if (LEN_W'(i) < len) mask[i] = 1'b1;
    end
  end

  assign hit = enough && (((window ^ pattern) & mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history   <= '0;
      bits_seen <= '0;
    end else if (clear) begin
      history   <= '0;
      bits_seen <= '0;
    end else if (shift) begin
      history <= window[PAT_W-2:0];
      if (bits_seen != LEN_W'(PAT_W)) bits_seen <= bits_seen + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config registers, run FSM, match and timeout counters.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TO_W  = DEF_TO_W
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  localparam int LEN_W = len_w(PAT_W);

  logic [1:0]       state;
  logic [PAT_W-1:0] pattern_r;
  logic [LEN_W-1:0] len_r;
  logic [CNT_W-1:0] target_r;
  logic [TO_W-1:0]  timeout_r;
  logic [TO_W-1:0]  bit_cnt;
  logic [CNT_W-1:0] match_cnt_r;
  logic             match_r;
  logic             cfg_err_r;

  logic             hit;
  logic             cfg_ok;
  logic             arm;
  logic             arm_ok;
  logic             shift;
  logic [CNT_W-1:0] cnt_nxt;
  logic [TO_W-1:0]  bits_nxt;

  assign cfg_ok   = (len_r != '0) && (len_r <= LEN_W'(PAT_W)) && (target_r != '0);
  assign arm      = bus.start && !bus.abort && (state != ST_RUN);
  assign arm_ok   = arm && cfg_ok;
  assign shift    = (state == ST_RUN) && bus.x_valid && !bus.abort;
  assign cnt_nxt  = match_cnt_r + CNT_W'(1);
  assign bits_nxt = bit_cnt + TO_W'(1);

  seq_window_match #(.PAT_W(PAT_W)) u_window (
    .clk     (clk),
    .rst     (rst),
    .clear   (arm_ok),
    .shift   (shift),
    .x       (bus.x),
    .pattern (pattern_r),
    .len     (len_r),
    .hit     (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pattern_r   <= '0;
      len_r       <= '0;
      target_r    <= '0;
      timeout_r   <= '0;
      bit_cnt     <= '0;
      match_cnt_r <= '0;
      match_r     <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      match_r <= 1'b0;

      if (bus.cfg_load && (state != ST_RUN)) begin
        pattern_r <= bus.cfg_pattern;
        len_r     <= bus.cfg_len;
        target_r  <= bus.cfg_target;
        timeout_r <= bus.cfg_timeout;
      end

      if (bus.abort) begin
        state <= ST_IDLE;
      end else if (arm) begin
        if (cfg_ok) begin
          state       <= ST_RUN;
          bit_cnt     <= '0;
          match_cnt_r <= '0;
          cfg_err_r   <= 1'b0;
        end else begin
          state     <= ST_IDLE;
          cfg_err_r <= 1'b1;
        end
      end else if (shift) begin
        bit_cnt <= bits_nxt;
        if (hit) begin
          match_r     <= 1'b1;
          match_cnt_r <= cnt_nxt;
        end
        // Target completion takes priority over a coincident timeout.
        if (hit && (cnt_nxt == target_r)) begin
          state <= ST_DONE;
        end else if ((timeout_r != '0) && (bits_nxt == timeout_r)) begin
          state <= ST_TMO;
        end
      end
    end
  end

  assign bus.match     = match_r;
  assign bus.match_cnt = match_cnt_r;
  assign bus.busy      = (state == ST_RUN);
  assign bus.done      = (state == ST_DONE);
  assign bus.timeout   = (state == ST_TMO);
  assign bus.cfg_err   = cfg_err_r;

endmodule
